// File: rtl/rvfi_check_pkg.sv
// Shared types and helpers for the rvfi_* PC checkers.
// Slot PCs are held at the widest supported width; narrower PCs are zero-extended.
package rvfi_check_pkg;

   localparam int ORDER_W   = 64;
   localparam int SLOT_XLEN = 64;

   typedef struct packed {
      logic                 rd_v;
      logic                 wr_v;
      logic [SLOT_XLEN-1:0] rd;
      logic [SLOT_XLEN-1:0] wr;
   } slot_t;

   function automatic logic pc_eq(input logic [SLOT_XLEN-1:0] a,
                                  input logic [SLOT_XLEN-1:0] b,
                                  input logic                 ignore_lsb);
      logic [SLOT_XLEN-1:0] mask;
      mask = ignore_lsb ? ~SLOT_XLEN'(1) : '1;
      return ((a ^ b) & mask) == '0;
   endfunction

endpackage

// File: rtl/rvfi_order_slot_sel.sv
// Maps each retirement channel onto a window slot (one-hot per slot), lowest
// channel wins a contested slot and the contest is flagged as a duplicate.
module rvfi_order_slot_sel
   import rvfi_check_pkg::*;
#(
   parameter int NRET  = 1,
   parameter int DEPTH = 4
) (
   input  logic [ORDER_W-1:0]      base_order,
   input  logic [NRET-1:0]         rvfi_valid,
   input  logic [NRET*ORDER_W-1:0] rvfi_order,
   output logic [DEPTH*NRET-1:0]   slot_sel,
   output logic                    dup
);

   logic [ORDER_W-1:0] idx [NRET];

   // Unsigned difference: orders below base wrap to huge values and miss every slot.
   always_comb begin
      for (int c = 0; c < NRET; c++) begin
         idx[c] = rvfi_order[c*ORDER_W +: ORDER_W] - base_order;
      end
   end

   always_comb begin
      slot_sel = '0;
      dup      = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         for (int c = 0; c < NRET; c++) begin
            if (rvfi_valid[c] && (idx[c] == ORDER_W'(k))) begin
               if (|slot_sel[k*NRET +: NRET]) begin
                  dup = 1'b1;
               end else begin
                  slot_sel[k*NRET + c] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rvfi_pc_window_check.sv
// Checks PC continuity (pc_wdata of k == pc_rdata of k+1) across a window of DEPTH orders.
// Rollback handling is compiled in with RVFI_PC_WINDOW_ROLLBACK_EN.
module rvfi_pc_window_check
   import rvfi_check_pkg::*;
#(
   parameter int NRET       = 1,
   parameter int XLEN       = 32,
   parameter int DEPTH      = 4,
   parameter int IGNORE_LSB = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       check_en,
   input  logic [ORDER_W-1:0]         base_order,
   input  logic [NRET-1:0]            rvfi_valid,
   input  logic [NRET*ORDER_W-1:0]    rvfi_order,
   input  logic [NRET*XLEN-1:0]       rvfi_pc_rdata,
   input  logic [NRET*XLEN-1:0]       rvfi_pc_wdata,
   input  logic                       rvfi_rollback_valid,
   input  logic [ORDER_W-1:0]         rvfi_rollback_order,
   output logic                       mismatch,
   output logic [ORDER_W-1:0]         mismatch_order,
   output logic                       dup_err,
   output logic [$clog2(DEPTH):0]     pairs_checked,
   output logic                       done
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int NPAIR = DEPTH - 1;

   logic [DEPTH*NRET-1:0] slot_sel;
   logic                  same_cycle_dup;

   rvfi_order_slot_sel #(
      .NRET  (NRET),
      .DEPTH (DEPTH)
   ) u_slot_sel (
      .base_order (base_order),
      .rvfi_valid (rvfi_valid),
      .rvfi_order (rvfi_order),
      .slot_sel   (slot_sel),
      .dup        (same_cycle_dup)
   );

   slot_t              slot_q [DEPTH];
   slot_t              slot_d [DEPTH];
   logic [NPAIR-1:0]   pair_done_q, pair_done_d;
   logic [CNT_W-1:0]   pairs_checked_q, pairs_checked_d;
   logic               mismatch_q, mismatch_d;
   logic [ORDER_W-1:0] mismatch_order_q, mismatch_order_d;
   logic               dup_err_q, dup_err_d;
   logic [CNT_W-1:0]   n_clr, n_new;
   logic               found;

`ifndef RVFI_PC_WINDOW_ROLLBACK_EN
   logic unused_rollback;
   assign unused_rollback = rvfi_rollback_valid ^ (^rvfi_rollback_order);
`endif

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         slot_d[k] = slot_q[k];
      end
      pair_done_d      = pair_done_q;
      mismatch_d       = 1'b0;
      mismatch_order_d = mismatch_order_q;
      dup_err_d        = dup_err_q | same_cycle_dup;
      n_clr            = '0;
      n_new            = '0;
      found            = 1'b0;

`ifdef RVFI_PC_WINDOW_ROLLBACK_EN
      // Rollback strikes first so a same-cycle retirement of a discarded order survives.
      if (rvfi_rollback_valid) begin
         for (int k = 0; k < DEPTH; k++) begin
            if ((base_order + ORDER_W'(k)) >= rvfi_rollback_order) begin
               slot_d[k].rd_v = 1'b0;
               slot_d[k].wr_v = 1'b0;
            end
         end
         for (int k = 0; k < NPAIR; k++) begin
            if (((base_order + ORDER_W'(k)) >= rvfi_rollback_order) && pair_done_d[k]) begin
               pair_done_d[k] = 1'b0;
               n_clr          = n_clr + CNT_W'(1);
            end
         end
      end
`endif

      for (int k = 0; k < DEPTH; k++) begin
         if (|slot_sel[k*NRET +: NRET]) begin
            if (slot_d[k].rd_v || slot_d[k].wr_v) begin
               dup_err_d = 1'b1;
            end
            slot_d[k].rd_v = 1'b1;
            slot_d[k].wr_v = 1'b1;
            for (int c = 0; c < NRET; c++) begin
               if (slot_sel[k*NRET + c]) begin
                  slot_d[k].rd = SLOT_XLEN'(rvfi_pc_rdata[c*XLEN +: XLEN]);
                  slot_d[k].wr = SLOT_XLEN'(rvfi_pc_wdata[c*XLEN +: XLEN]);
               end
            end
         end
      end

      // Pairs are judged on post-capture state; lowest failing k is reported.
      for (int k = 0; k < NPAIR; k++) begin
         if (slot_d[k].wr_v && slot_d[k+1].rd_v && !pair_done_d[k]) begin
            pair_done_d[k] = 1'b1;
            n_new          = n_new + CNT_W'(1);
            if (check_en && !found &&
                !pc_eq(slot_d[k].wr, slot_d[k+1].rd, IGNORE_LSB != 0)) begin
               found            = 1'b1;
               mismatch_d       = 1'b1;
               mismatch_order_d = base_order + ORDER_W'(k);
            end
         end
      end

      pairs_checked_d = pairs_checked_q - n_clr + n_new;
   end

   always_ff @(posedge clock) begin
      for (int k = 0; k < DEPTH; k++) begin
         slot_q[k] <= slot_d[k];
      end
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_q[k].rd_v <= 1'b0;
            slot_q[k].wr_v <= 1'b0;
         end
         pair_done_q      <= '0;
         pairs_checked_q  <= '0;
         mismatch_q       <= 1'b0;
         mismatch_order_q <= '0;
         dup_err_q        <= 1'b0;
      end else begin
         pair_done_q      <= pair_done_d;
         pairs_checked_q  <= pairs_checked_d;
         mismatch_q       <= mismatch_d;
         mismatch_order_q <= mismatch_order_d;
         dup_err_q        <= dup_err_d;
      end
   end

   assign mismatch       = mismatch_q;
   assign mismatch_order = mismatch_order_q;
   assign dup_err        = dup_err_q;
   assign pairs_checked  = pairs_checked_q;
   assign done           = (pairs_checked_q == CNT_W'(NPAIR));

`ifdef FORMAL
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!mismatch && !dup_err);
      end
`ifndef RVFI_PC_WINDOW_ROLLBACK_EN
      assume (!rvfi_rollback_valid);
`endif
   end
`endif

endmodule

// File: tb/tb_rvfi_pc_window_check.sv
// Randomised scoreboard bench for rvfi_pc_window_check (two instances: IGNORE_LSB 1 and 0).
module tb_rvfi_pc_window_check;

   localparam int NRET  = 2;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 check_en = 1'b1;
   logic [63:0]          base_order = '0;
   logic [NRET-1:0]      rvfi_valid = '0;
   logic [NRET*64-1:0]   rvfi_order = '0;
   logic [NRET*XLEN-1:0] rvfi_pc_rdata = '0;
   logic [NRET*XLEN-1:0] rvfi_pc_wdata = '0;
   logic                 rb_valid = 1'b0;
   logic [63:0]          rb_order = '0;

   logic        mm1, mm0, dup1, dup0, done1, done0;
   logic [63:0] mmo1, mmo0;
   logic [2:0]  pc1, pc0;

   rvfi_pc_window_check #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .IGNORE_LSB(1)) dut1 (
      .clock(clock), .reset(reset), .check_en(check_en), .base_order(base_order),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_pc_rdata(rvfi_pc_rdata),
      .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_rollback_valid(rb_valid),
      .rvfi_rollback_order(rb_order), .mismatch(mm1), .mismatch_order(mmo1),
      .dup_err(dup1), .pairs_checked(pc1), .done(done1));

   rvfi_pc_window_check #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .IGNORE_LSB(0)) dut0 (
      .clock(clock), .reset(reset), .check_en(check_en), .base_order(base_order),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_pc_rdata(rvfi_pc_rdata),
      .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_rollback_valid(rb_valid),
      .rvfi_rollback_order(rb_order), .mismatch(mm0), .mismatch_order(mmo0),
      .dup_err(dup0), .pairs_checked(pc0), .done(done0));

   always #5 clock = ~clock;

   typedef struct packed {
      logic        mm1;
      logic        mm0;
      logic [63:0] mmo1;
      logic [63:0] mmo0;
      logic        dup;
      logic [2:0]  pairs;
      logic        done;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: what has been seen per window position, and which pairs were judged.
   bit          m_rdv [DEPTH];
   bit          m_wrv [DEPTH];
   logic [31:0] m_rd  [DEPTH];
   logic [31:0] m_wr  [DEPTH];
   bit          m_pd  [DEPTH];
   bit          m_dup;
   logic [63:0] m_mmo [2];

   function automatic bit differ(input logic [31:0] a, input logic [31:0] b, input bit ign);
      return ign ? (a[31:1] != b[31:1]) : (a != b);
   endfunction

   task automatic model_step(output exp_t e);
      bit          claimed [DEPTH];
      bit          found   [2];
      logic [63:0] d;
      int          cnt;
      e = '0;
      for (int k = 0; k < DEPTH; k++) claimed[k] = 1'b0;
      found[0] = 1'b0;
      found[1] = 1'b0;
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            m_rdv[k] = 1'b0; m_wrv[k] = 1'b0; m_pd[k] = 1'b0;
         end
         m_dup    = 1'b0;
         m_mmo[0] = '0;
         m_mmo[1] = '0;
      end else begin
`ifdef RVFI_PC_WINDOW_ROLLBACK_EN
         if (rb_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (base_order + 64'(k) >= rb_order) begin
                  m_rdv[k] = 1'b0; m_wrv[k] = 1'b0; m_pd[k] = 1'b0;
               end
            end
         end
`endif
         for (int c = 0; c < NRET; c++) begin
            if (rvfi_valid[c]) begin
               d = rvfi_order[c*64 +: 64] - base_order;
               if (d < 64'(DEPTH)) begin
                  if (claimed[d[1:0]]) begin
                     m_dup = 1'b1;
                  end else begin
                     claimed[d[1:0]] = 1'b1;
                     if (m_rdv[d[1:0]]) m_dup = 1'b1;
                     m_rdv[d[1:0]] = 1'b1;
                     m_wrv[d[1:0]] = 1'b1;
                     m_rd[d[1:0]]  = rvfi_pc_rdata[c*XLEN +: XLEN];
                     m_wr[d[1:0]]  = rvfi_pc_wdata[c*XLEN +: XLEN];
                  end
               end
            end
         end
         for (int k = 0; k < DEPTH-1; k++) begin
            if (m_wrv[k] && m_rdv[k+1] && !m_pd[k]) begin
               m_pd[k] = 1'b1;
               for (int i = 0; i < 2; i++) begin
                  if (check_en && !found[i] && differ(m_wr[k], m_rd[k+1], i == 1)) begin
                     found[i] = 1'b1;
                     m_mmo[i] = base_order + 64'(k);
                  end
               end
            end
         end
      end
      cnt = 0;
      for (int k = 0; k < DEPTH-1; k++) cnt += int'(m_pd[k]);
      e.mm1   = found[1];
      e.mm0   = found[0];
      e.mmo1  = m_mmo[1];
      e.mmo0  = m_mmo[0];
      e.dup   = m_dup;
      e.pairs = 3'(cnt);
      e.done  = (cnt == DEPTH-1);
   endtask

   task automatic idle();
      rvfi_valid = '0;
      rb_valid   = 1'b0;
   endtask

   task automatic setch(input int c, input logic [63:0] ord, input logic [31:0] rd,
                        input logic [31:0] wr);
      rvfi_valid[c]               = 1'b1;
      rvfi_order[c*64 +: 64]      = ord;
      rvfi_pc_rdata[c*XLEN +: XLEN] = rd;
      rvfi_pc_wdata[c*XLEN +: XLEN] = wr;
   endtask

   // Called at a negedge: model this cycle, queue the expectation, advance one cycle.
   task automatic cycle();
      exp_t e;
      model_step(e);
      sb.push_back(e);
      @(negedge clock);
      idle();
   endtask

   task automatic do_reset(input logic [63:0] base);
      reset      = 1'b1;
      base_order = base;
      cycle();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] pcf(input logic [63:0] o);
      return 32'h1000 + {o[29:0], 2'b00};
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mismatch_i1", 64'(mm1), 64'(e.mm1));
            chk("mismatch_i0", 64'(mm0), 64'(e.mm0));
            chk("mismatch_order_i1", mmo1, e.mmo1);
            chk("mismatch_order_i0", mmo0, e.mmo0);
            chk("dup_err_i1", 64'(dup1), 64'(e.dup));
            chk("dup_err_i0", 64'(dup0), 64'(e.dup));
            chk("pairs_checked_i1", 64'(pc1), 64'(e.pairs));
            chk("pairs_checked_i0", 64'(pc0), 64'(e.pairs));
            chk("done_i1", 64'(done1), 64'(e.done));
            chk("done_i0", 64'(done0), 64'(e.done));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [63:0] o;
      @(negedge clock);

      // Sequential orders with consistent PCs
      do_reset(64'd10);
      for (int i = 0; i < 4; i++) begin
         setch(0, 64'd10 + 64'(i), 32'h100 + 32'(4*i), 32'h104 + 32'(4*i));
         cycle();
      end
      chk("seq_pairs", 64'(pc1), 64'd3);
      chk("seq_done", 64'(done1), 64'd1);

      // Successor retires first, predecessor's wdata disagrees
      do_reset(64'd0);
      setch(0, 64'd1, 32'h204, 32'h208);
      cycle();
      setch(1, 64'd0, 32'h1FC, 32'h200);
      cycle();
      chk("ooo_mismatch", 64'(mm1), 64'd1);
      chk("ooo_mismatch_order", mmo1, 64'd0);

      // Same order on both channels: ch0 data must be kept
      do_reset(64'd5);
      setch(0, 64'd5, 32'h500, 32'h504);
      setch(1, 64'd5, 32'h600, 32'h604);
      cycle();
      chk("dup_same_cycle", 64'(dup1), 64'd1);
      setch(0, 64'd6, 32'h504, 32'h508);
      cycle();
      chk("dup_ch0_kept", 64'(mm1), 64'd0);

      // Low-bit-only difference
      do_reset(64'd0);
      setch(0, 64'd0, 32'h2FC, 32'h301);
      cycle();
      setch(0, 64'd1, 32'h300, 32'h304);
      cycle();
      chk("lsb_ignored", 64'(mm1), 64'd0);
      chk("lsb_compared", 64'(mm0), 64'd1);

`ifdef RVFI_PC_WINDOW_ROLLBACK_EN
      do_reset(64'd0);
      setch(0, 64'd0, 32'h3FC, 32'h400); cycle();
      setch(0, 64'd1, 32'h400, 32'h408); cycle();
      setch(0, 64'd2, 32'h408, 32'h40C); cycle();
      rb_valid = 1'b1;
      rb_order = 64'd1;
      setch(0, 64'd1, 32'h404, 32'h410);
      cycle();
      chk("rollback_pairs", 64'(pc1), 64'd1);
      setch(0, 64'd2, 32'h410, 32'h414);
      cycle();
      chk("rollback_refill", 64'(mm1), 64'd0);
`endif

      // Out-of-window orders, a duplicate, then reset mid-run
      do_reset(64'd20);
      setch(0, 64'd20, pcf(20), pcf(21));
      setch(1, 64'd24, 32'hDEAD, 32'hBEEF);
      cycle();
      setch(0, 64'd21, pcf(21), pcf(22));
      setch(1, 64'd19, 32'hDEAD, 32'hBEEF);
      cycle();
      setch(0, 64'd22, pcf(22), pcf(23));
      setch(1, 64'd22, 32'h0, 32'h0);
      cycle();
      chk("window_pairs", 64'(pc1), 64'd2);
      reset = 1'b1;
      setch(0, 64'd23, 32'hBAD0, 32'hBAD4);
      cycle();
      reset = 1'b0;
      chk("reset_pairs", 64'(pc1), 64'd0);
      chk("reset_dup", 64'(dup1), 64'd0);
      chk("reset_mismatch", 64'(mm0), 64'd0);

      // Random traffic around the window, periodic resets with fresh bases
      for (int it = 0; it < 600; it++) begin
         if (it % 40 == 0) begin
            if ($urandom_range(0, 3) == 0) do_reset(64'hFFFF_FFFF_FFFF_FFFE);
            else do_reset({$urandom, $urandom});
         end
         check_en = ($urandom_range(0, 7) != 0);
         for (int c = 0; c < NRET; c++) begin
            if ($urandom_range(0, 1) == 1) begin
               o = base_order + 64'($urandom_range(0, DEPTH + 1)) - 64'd1;
               setch(c, o, pcf(o),
                     pcf(o + 64'd1) ^ (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0)
                                    ^ (($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0));
            end
         end
`ifdef RVFI_PC_WINDOW_ROLLBACK_EN
         if ($urandom_range(0, 15) == 0) begin
            rb_valid = 1'b1;
            rb_order = base_order + 64'($urandom_range(0, DEPTH));
         end
`endif
         cycle();
      end

      @(posedge clock);
      #2;
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
